// File: rtl/dat_mem_dma.sv
// dat_mem_dma: block-copy initiator on the single-port data memory.
// Copies len bytes from src to dst using a READ/WRITE cycle pair per byte.
// When dst lies inside the source window, the copy runs in descending order.
// Optional feature macro: DMA_CHECKSUM_EN adds the csum output, which is the
// 8-bit modular sum of the bytes written in the current transfer.
module dat_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          desc_q, desc_d;
  logic [DW-1:0] data_q, data_d;
`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  // Direction decision is made in AW+1 bits, so src+len never wraps here.
  logic [AW:0]   src_ext_s;
  logic [AW:0]   dst_ext_s;
  logic [AW:0]   src_end_s;
  logic          overlap_desc_s;
  logic [AW-1:0] src_last_s;
  logic [AW-1:0] dst_last_s;

  assign src_ext_s      = {1'b0, src};
  assign dst_ext_s      = {1'b0, dst};
  assign src_end_s      = src_ext_s + len;
  assign overlap_desc_s = (dst_ext_s > src_ext_s) && (dst_ext_s < src_end_s);
  // The last byte of each window is found modulo 2**AW; len=2**AW lands on base-1.
  assign src_last_s     = src + len[AW-1:0] - PTR_ONE;
  assign dst_last_s     = dst + len[AW-1:0] - PTR_ONE;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      desc_q   <= 1'b0;
      data_q   <= '0;
`ifdef DMA_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      desc_q   <= desc_d;
      data_q   <= data_d;
`ifdef DMA_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Next-state logic: accept, read/write alternation, pointer stepping.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    desc_d   = desc_q;
    data_d   = data_q;
`ifdef DMA_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DMA_CHECKSUM_EN
          csum_d = '0;
`endif
          if (len != CNT_ZERO) begin
            desc_d  = overlap_desc_s;
            cnt_d   = len;
            state_d = S_READ;
            if (overlap_desc_s) begin
              rd_ptr_d = src_last_s;
              wr_ptr_d = dst_last_s;
            end else begin
              rd_ptr_d = src;
              wr_ptr_d = dst;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        data_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (desc_q) begin
          rd_ptr_d = rd_ptr_q - PTR_ONE;
          wr_ptr_d = wr_ptr_q - PTR_ONE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        cnt_d = cnt_q - CNT_ONE;
`ifdef DMA_CHECKSUM_EN
        csum_d = csum_q + data_q;
`endif
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; write data always shows the latch.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = data_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = rd_ptr_q;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_addr  = wr_ptr_q;
        mem_wr_en = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef DMA_CHECKSUM_EN
  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_dat_mem_dma.sv
// Directed self-checking bench for dat_mem_dma with a behavioural memory.
// Cycle numbering: the accept edge is edge 0; cycle c is the period after edge c-1.
module tb_dat_mem_dma;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef DMA_CHECKSUM_EN
  logic [7:0] csum;
`endif

  logic [7:0] mem [0:255];

  int n_chk = 0;
  int n_pass = 0;

  int done_cyc, done_cnt, busy_cnt, busy_first, busy_last;
  int wr_cyc[$];
  int wr_adr[$];
  int rd_adr[$];
  int csum_done, csum_c1;

  dat_mem_dma #(.AW(8), .DW(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src(src),
    .dst(dst),
    .len(len),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMA_CHECKSUM_EN
    ,
    .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Launch one transfer and observe ncyc cycles; optional reset / extra start.
  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                     input int ncyc, input int rst_c, input int bs_c);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
    wr_cyc.delete(); wr_adr.delete(); rd_adr.delete();
    csum_done = -1; csum_c1 = -1;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
`ifdef DMA_CHECKSUM_EN
        csum_done = int'(csum);
`endif
      end
`ifdef DMA_CHECKSUM_EN
      if (c == 1) csum_c1 = int'(csum);
`endif
      if (mem_wr_en) begin
        wr_cyc.push_back(c);
        wr_adr.push_back(int'(mem_addr));
      end
      if (busy && !mem_wr_en && !done) rd_adr.push_back(int'(mem_addr));
      if (c == rst_c) reset = 1'b1;
      if (c == bs_c) begin
        start = 1'b1; src = 8'h00; dst = 8'h90; len = 9'd2;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src = 8'h00; dst = 8'h00; len = 9'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic ascending copy.
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    run(8'h10, 8'h40, 9'd4, 12, -1, -1);
    chk("asc_done_cyc", done_cyc, 9);
    chk("asc_done_cnt", done_cnt, 1);
    chk("asc_busy_first", busy_first, 1);
    chk("asc_busy_last", busy_last, 9);
    chk("asc_busy_cnt", busy_cnt, 9);
    chk("asc_nwr", wr_cyc.size(), 4);
    chk("asc_wr0_cyc", q_at(wr_cyc, 0), 2);
    chk("asc_wr3_cyc", q_at(wr_cyc, 3), 8);
    chk("asc_d40", int'(mem[8'h40]), 8'h11);
    chk("asc_d41", int'(mem[8'h41]), 8'h22);
    chk("asc_d42", int'(mem[8'h42]), 8'h33);
    chk("asc_d43", int'(mem[8'h43]), 8'h44);
    chk("asc_s10", int'(mem[8'h10]), 8'h11);
    chk("asc_s13", int'(mem[8'h13]), 8'h44);

    // Overlapping forward move needs a descending copy.
    for (int i = 0; i < 5; i++) mem[8'h20 + i] = 8'(i + 1);
    mem[8'h25] = 8'h00; mem[8'h26] = 8'h00;
    run(8'h20, 8'h22, 9'd5, 14, -1, -1);
    chk("ovl_first_wr", q_at(wr_adr, 0), 8'h26);
    chk("ovl_first_rd", q_at(rd_adr, 0), 8'h24);
    chk("ovl_done_cyc", done_cyc, 11);
    for (int i = 0; i < 5; i++) chk($sformatf("ovl_d%0h", 8'h22 + i), int'(mem[8'h22 + i]), i + 1);

    // Ascending copy whose source wraps past 0xFF.
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hA2; mem[8'h00] = 8'hA3; mem[8'h01] = 8'hA4;
    run(8'hFE, 8'h80, 9'd4, 12, -1, -1);
    chk("wrap_rd0", q_at(rd_adr, 0), 8'hFE);
    chk("wrap_rd1", q_at(rd_adr, 1), 8'hFF);
    chk("wrap_rd2", q_at(rd_adr, 2), 8'h00);
    chk("wrap_rd3", q_at(rd_adr, 3), 8'h01);
    chk("wrap_d80", int'(mem[8'h80]), 8'hA1);
    chk("wrap_d83", int'(mem[8'h83]), 8'hA4);

    // Descending copy whose destination wraps past 0xFF.
    mem[8'hFC] = 8'hB1; mem[8'hFD] = 8'hB2; mem[8'hFE] = 8'hB3; mem[8'hFF] = 8'hB4;
    run(8'hFC, 8'hFE, 9'd4, 12, -1, -1);
    chk("dwrap_first_rd", q_at(rd_adr, 0), 8'hFF);
    chk("dwrap_first_wr", q_at(wr_adr, 0), 8'h01);
    chk("dwrap_dFE", int'(mem[8'hFE]), 8'hB1);
    chk("dwrap_dFF", int'(mem[8'hFF]), 8'hB2);
    chk("dwrap_d00", int'(mem[8'h00]), 8'hB3);
    chk("dwrap_d01", int'(mem[8'h01]), 8'hB4);

    // Zero-length request completes without memory access.
    run(8'h10, 8'h60, 9'd0, 5, -1, -1);
    chk("len0_done_cyc", done_cyc, 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_nwr", wr_cyc.size(), 0);
    chk("len0_busy_cnt", busy_cnt, 1);

    // Reset during an 8-byte transfer: only two bytes land.
    for (int i = 0; i < 8; i++) begin
      mem[8'h30 + i] = 8'(8'hC0 + i);
      mem[8'h50 + i] = 8'hEE;
    end
    run(8'h30, 8'h50, 9'd8, 14, 5, -1);
    chk("rst_nwr", wr_cyc.size(), 2);
    chk("rst_wr0_cyc", q_at(wr_cyc, 0), 2);
    chk("rst_wr1_cyc", q_at(wr_cyc, 1), 4);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_busy_last", busy_last, 5);
    chk("rst_d50", int'(mem[8'h50]), 8'hC0);
    chk("rst_d51", int'(mem[8'h51]), 8'hC1);
    chk("rst_d52", int'(mem[8'h52]), 8'hEE);

    // Start pulse while busy is ignored.
    mem[8'h60] = 8'h5A; mem[8'h61] = 8'h6B; mem[8'h62] = 8'h7C;
    run(8'h60, 8'h70, 9'd3, 14, -1, 4);
    chk("bsy_done_cnt", done_cnt, 1);
    chk("bsy_done_cyc", done_cyc, 7);
    chk("bsy_nwr", wr_cyc.size(), 3);
    chk("bsy_d72", int'(mem[8'h72]), 8'h7C);

    // src equal to dst still runs the full cycle count.
    run(8'h60, 8'h60, 9'd3, 10, -1, -1);
    chk("same_done_cyc", done_cyc, 7);
    chk("same_nwr", wr_cyc.size(), 3);
    chk("same_d61", int'(mem[8'h61]), 8'h6B);

`ifdef DMA_CHECKSUM_EN
    mem[8'hA0] = 8'h80; mem[8'hA1] = 8'h90; mem[8'hA2] = 8'h01;
    run(8'hA0, 8'hB0, 9'd3, 9, -1, -1);
    chk("csum_done", csum_done, 8'h11);
    run(8'hA0, 8'hC0, 9'd1, 5, -1, -1);
    chk("csum_clear", csum_c1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
